// File: rtl/conn_table_searcher.sv
// conn_table_searcher: TCP connection table with linear-scan lookup, lookup-or-insert and
// delete-by-id. Keys live in a sync RAM, validity in a flop bitmap.
`default_nettype none

module conn_table_searcher #(
  parameter int DEPTH  = 256,
  parameter int MAC_W  = 48,
  parameter int IP_W   = 32,
  parameter int PORT_W = 16,
  localparam int ID_W  = $clog2(DEPTH),
  localparam int KEY_W = 2*(MAC_W+IP_W+PORT_W)
) (
  input  logic              cs_clk,
  input  logic              cs_rst_n,
  input  logic              cs_req_valid,
  output logic              cs_req_ready,
  input  logic [1:0]        cs_rq,
  input  logic [ID_W-1:0]   cs_id_in,
  input  logic [MAC_W-1:0]  cs_mac_src,
  input  logic [MAC_W-1:0]  cs_mac_dst,
  input  logic [IP_W-1:0]   cs_ip_src,
  input  logic [IP_W-1:0]   cs_ip_dst,
  input  logic [PORT_W-1:0] cs_port_src,
  input  logic [PORT_W-1:0] cs_port_dst,
  output logic              cs_done,
  output logic [ID_W-1:0]   cs_id_out,
  output logic [7:0]        cs_error,
  output logic [ID_W:0]     cs_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DEL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] RQ_INS  = 2'b01;
  localparam logic [1:0] RQ_DEL  = 2'b10;
  localparam logic [1:0] RQ_LOOK = 2'b11;

  localparam logic [7:0] E_OK     = 8'h00;
  localparam logic [7:0] E_EXISTS = 8'h01;
  localparam logic [7:0] E_NEW    = 8'h02;
  localparam logic [7:0] E_FULL   = 8'h03;
  localparam logic [7:0] E_NOTFND = 8'h04;

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(DEPTH-1);
  localparam logic [ID_W:0]   ONE_W1   = (ID_W+1)'(1);

  logic [2:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q;
  logic [1:0]       rq_q;
  logic [ID_W-1:0]  del_id_q;
  logic [ID_W:0]    addr_q;
  logic             cmp_valid_q;
  logic [ID_W-1:0]  cmp_idx_q;
  logic [KEY_W-1:0] ram_q;
  logic             free_found_q;
  logic [ID_W-1:0]  free_idx_q;
  logic [DEPTH-1:0] bitmap_q;
  logic [ID_W:0]    count_q;
  logic [ID_W-1:0]  id_out_q;
  logic [7:0]       err_q;
  logic [KEY_W-1:0] mem [DEPTH];

  logic w_accept, w_hit, w_last, w_issue, w_do_write;

  assign w_accept   = cs_req_valid && (state_q == S_IDLE);
  assign w_hit      = cmp_valid_q && bitmap_q[cmp_idx_q] && (ram_q == key_q);
  assign w_last     = cmp_valid_q && (cmp_idx_q == LAST_IDX);
  assign w_issue    = (state_q == S_SCAN) && !addr_q[ID_W];
  assign w_do_write = (state_q == S_WRITE) && (rq_q == RQ_INS) && free_found_q;

  always_ff @(posedge cs_clk or negedge cs_rst_n) begin
    if (!cs_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (cs_rq)
            RQ_INS, RQ_LOOK: state_d = S_SCAN;
            RQ_DEL:          state_d = S_DEL;
            default:         state_d = S_IDLE;
          endcase
        end
      end
      S_SCAN: begin
        if (w_hit)       state_d = S_DONE;
        else if (w_last) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DEL:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs_req_ready = (state_q == S_IDLE);
    cs_done      = (state_q == S_DONE);
  end

  assign cs_id_out = id_out_q;
  assign cs_error  = err_q;
  assign cs_count  = count_q;

  // Key RAM: no reset, contents only meaningful where the bitmap says so.
  always_ff @(posedge cs_clk) begin
    if (w_do_write) mem[free_idx_q] <= key_q;
    ram_q <= mem[addr_q[ID_W-1:0]];
  end

  always_ff @(posedge cs_clk or negedge cs_rst_n) begin
    if (!cs_rst_n) begin
      key_q        <= '0;
      rq_q         <= '0;
      del_id_q     <= '0;
      addr_q       <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      bitmap_q     <= '0;
      count_q      <= '0;
      id_out_q     <= '0;
      err_q        <= E_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            key_q        <= {cs_mac_src, cs_mac_dst, cs_ip_src, cs_ip_dst, cs_port_src, cs_port_dst};
            rq_q         <= cs_rq;
            del_id_q     <= cs_id_in;
            addr_q       <= '0;
            cmp_valid_q  <= 1'b0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
          end
        end
        S_SCAN: begin
          if (w_issue) addr_q <= addr_q + ONE_W1;
          cmp_valid_q <= w_issue && !w_hit;
          cmp_idx_q   <= addr_q[ID_W-1:0];
          // Lowest free slot comes from the bitmap alone, in scan order.
          if (cmp_valid_q && !bitmap_q[cmp_idx_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= cmp_idx_q;
          end
          if (w_hit) begin
            id_out_q <= cmp_idx_q;
            err_q    <= (rq_q == RQ_LOOK) ? E_OK : E_EXISTS;
          end
        end
        S_WRITE: begin
          if (w_do_write) begin
            bitmap_q[free_idx_q] <= 1'b1;
            count_q              <= count_q + ONE_W1;
            id_out_q             <= free_idx_q;
            err_q                <= E_NEW;
          end else begin
            id_out_q <= '0;
            err_q    <= (rq_q == RQ_INS) ? E_FULL : E_NOTFND;
          end
        end
        S_DEL: begin
          id_out_q <= del_id_q;
          if (bitmap_q[del_id_q]) begin
            bitmap_q[del_id_q] <= 1'b0;
            count_q            <= count_q - ONE_W1;
            err_q              <= E_OK;
          end else begin
            err_q <= E_NOTFND;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conn_table_searcher.sv
// tb_conn_table_searcher: directed table, randomized ops against a behavioural table model,
// and hand sequences for busy-request rejection and mid-scan reset.
`default_nettype none

module tb_conn_table_searcher;

  localparam int DEPTH  = 4;
  localparam int ID_W   = 2;
  localparam int KEY_W  = 192;

  typedef logic [KEY_W-1:0] key_t;

  typedef struct {
    logic [1:0] rq;
    int key;
    int id;
    int has_done;
    int exp_id;
    int exp_err;
    int exp_lat;
    int exp_cnt;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      rq;
  logic [ID_W-1:0] id_in;
  logic [47:0]     mac_src, mac_dst;
  logic [31:0]     ip_src, ip_dst;
  logic [15:0]     port_src, port_dst;
  logic            done;
  logic [ID_W-1:0] id_out;
  logic [7:0]      err;
  logic [ID_W:0]   count;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  key_t m_key [DEPTH];
  bit   m_val [DEPTH];

  conn_table_searcher #(.DEPTH(DEPTH)) dut (
    .cs_clk(clk), .cs_rst_n(rst_n), .cs_req_valid(req_valid), .cs_req_ready(req_ready),
    .cs_rq(rq), .cs_id_in(id_in),
    .cs_mac_src(mac_src), .cs_mac_dst(mac_dst), .cs_ip_src(ip_src), .cs_ip_dst(ip_dst),
    .cs_port_src(port_src), .cs_port_dst(port_dst),
    .cs_done(done), .cs_id_out(id_out), .cs_error(err), .cs_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic key_t key_of(input int n);
    logic [47:0] a, b;
    logic [31:0] c, d;
    logic [15:0] e, f;
    a = 48'(n * 7 + 1);
    b = 48'(n * 13 + 5) << 20;
    c = 32'(n * 101);
    d = ~32'(n);
    e = 16'(n * 3 + 2);
    f = 16'(n + 100);
    return {a, b, c, d, e, f};
  endfunction

  task automatic drive_key(input key_t k);
    {mac_src, mac_dst, ip_src, ip_dst, port_src, port_dst} = k;
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) m_val[k] = 1'b0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int k = 0; k < DEPTH; k++) c += int'(m_val[k]);
    return c;
  endfunction

  // Table semantics: first valid match wins; otherwise insert into the lowest empty slot.
  task automatic model_apply(input logic [1:0] r, input key_t k, input int id,
                             output int has_done, output int e_id, output int e_err,
                             output int e_lat);
    int hit, fr;
    has_done = 1; e_id = 0; e_err = 0; e_lat = 0;
    hit = -1; fr = -1;
    if (r == 2'b00) begin
      has_done = 0;
    end else if (r == 2'b10) begin
      e_id = id; e_lat = 2;
      if (m_val[id]) begin m_val[id] = 1'b0; e_err = 0; end
      else e_err = 4;
    end else begin
      for (int s = 0; s < DEPTH; s++)
        if (hit < 0 && m_val[s] && m_key[s] == k) hit = s;
      if (hit >= 0) begin
        e_lat = 3 + hit; e_id = hit; e_err = (r == 2'b11) ? 0 : 1;
      end else begin
        e_lat = 3 + DEPTH;
        if (r == 2'b11) e_err = 4;
        else begin
          for (int s = 0; s < DEPTH; s++) if (fr < 0 && !m_val[s]) fr = s;
          if (fr >= 0) begin
            m_key[fr] = k; m_val[fr] = 1'b1; e_id = fr; e_err = 2;
          end else e_err = 3;
        end
      end
    end
  endtask

  // Called #1 after the accept edge (or later, between edges); tacc is cycle of accept edge.
  task automatic wait_done(input int tacc, input int bound, output int got, output int lat);
    got = 0; lat = 0;
    for (int m = 0; m < bound; m++) begin
      if (done) begin got = 1; lat = cyc - tacc + 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_req(input string tag, input logic [1:0] r, input key_t k, input int id,
                           input int has_done, input int e_id, input int e_err,
                           input int e_lat, input int e_cnt);
    int guard, got, lat, tacc;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      chk({tag, ".ready_wait"}, 0, 1);
      return;
    end
    rq = r; id_in = ID_W'(id); drive_key(k); req_valid = 1'b1;
    @(posedge clk); #1;
    tacc = cyc;
    req_valid = 1'b0; drive_key(~k); id_in = ~id_in; rq = ~r;
    wait_done(tacc, DEPTH + 12, got, lat);
    chk({tag, ".done"}, got, has_done);
    if (got != 0) begin
      chk({tag, ".lat"}, lat, e_lat);
      chk({tag, ".id"}, int'(id_out), e_id);
      chk({tag, ".err"}, int'(err), e_err);
      chk({tag, ".count"}, int'(count), e_cnt);
      @(posedge clk); #1;
      chk({tag, ".pulse"}, int'(done), 0);
      chk({tag, ".ready_back"}, int'(req_ready), 1);
    end else begin
      chk({tag, ".count"}, int'(count), e_cnt);
    end
    @(negedge clk);
  endtask

  task automatic model_req(input string tag, input logic [1:0] r, input key_t k, input int id);
    int hd, ei, ee, el;
    model_apply(r, k, id, hd, ei, ee, el);
    check_req(tag, r, k, id, hd, ei, ee, el, model_count());
  endtask

  vec_t tv [16];

  initial begin
    int hd, ei, ee, el, got, lat, tacc, seen;
    logic [1:0] rr;
    rst_n = 1'b0; req_valid = 1'b0; rq = 2'b00; id_in = '0; drive_key('0);
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst.ready", int'(req_ready), 1);
    chk("rst.done", int'(done), 0);
    chk("rst.id", int'(id_out), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.count", int'(count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    //          rq     key id done eid eerr lat cnt
    tv[0]  = '{2'b01, 1, 0, 1, 0, 2, 7, 1};
    tv[1]  = '{2'b01, 1, 0, 1, 0, 1, 3, 1};
    tv[2]  = '{2'b01, 2, 0, 1, 1, 2, 7, 2};
    tv[3]  = '{2'b01, 3, 0, 1, 2, 2, 7, 3};
    tv[4]  = '{2'b10, 0, 1, 1, 1, 0, 2, 2};
    tv[5]  = '{2'b01, 4, 0, 1, 1, 2, 7, 3};
    tv[6]  = '{2'b11, 3, 0, 1, 2, 0, 5, 3};
    tv[7]  = '{2'b10, 0, 3, 1, 3, 4, 2, 3};
    tv[8]  = '{2'b11, 5, 0, 1, 0, 4, 7, 3};
    tv[9]  = '{2'b01, 5, 0, 1, 3, 2, 7, 4};
    tv[10] = '{2'b01, 6, 0, 1, 0, 3, 7, 4};
    tv[11] = '{2'b11, 6, 0, 1, 0, 4, 7, 4};
    tv[12] = '{2'b11, 4, 0, 1, 1, 0, 4, 4};
    tv[13] = '{2'b10, 0, 0, 1, 0, 0, 2, 3};
    tv[14] = '{2'b00, 6, 0, 0, 0, 0, 0, 3};
    tv[15] = '{2'b01, 6, 0, 1, 0, 2, 7, 4};

    for (int i = 0; i < 16; i++) begin
      model_apply(tv[i].rq, key_of(tv[i].key), tv[i].id, hd, ei, ee, el);
      check_req($sformatf("tv%0d", i), tv[i].rq, key_of(tv[i].key), tv[i].id,
                tv[i].has_done, tv[i].exp_id, tv[i].exp_err, tv[i].exp_lat, tv[i].exp_cnt);
    end

    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      rr = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 6) ? 2'b10 : 2'b11;
      model_req($sformatf("rnd%0d", i), rr, key_of(10 + int'($urandom_range(0, 5))),
                int'($urandom_range(0, DEPTH - 1)));
    end

    // Busy: a request raised mid-scan must be ignored.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_clear(); @(negedge clk);
    model_req("busy.ins", 2'b01, key_of(200), 0);
    rq = 2'b11; drive_key(key_of(99)); req_valid = 1'b1;
    @(posedge clk); #1;
    tacc = cyc;
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rq = 2'b10; id_in = '0; drive_key(key_of(200)); req_valid = 1'b1;
    chk("busy.ready0", int'(req_ready), 0);
    @(negedge clk);
    chk("busy.ready1", int'(req_ready), 0);
    req_valid = 1'b0;
    wait_done(tacc, DEPTH + 12, got, lat);
    chk("busy.done", got, 1);
    chk("busy.lat", lat, 3 + DEPTH);
    chk("busy.err", int'(err), 4);
    chk("busy.id", int'(id_out), 0);
    chk("busy.count", int'(count), 1);
    @(negedge clk); @(negedge clk);
    model_req("busy.still_there", 2'b11, key_of(200), 0);

    // Reset in the middle of an insert scan.
    rq = 2'b01; drive_key(key_of(201)); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", int'(req_ready), 1);
    chk("midrst.count", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen = 0;
    for (int m = 0; m < DEPTH + 8; m++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst.no_done", seen, 0);
    chk("midrst.count_after", int'(count), 0);
    chk("midrst.ready_after", int'(req_ready), 1);
    @(negedge clk);
    model_req("midrst.old_gone", 2'b11, key_of(200), 0);
    model_req("midrst.no_write", 2'b11, key_of(201), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
